// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
// Shared video types and constants for the layered palette mapper.
//   rgb_t            : packed RGB888 colour (r, g, b; 8 bits each)
//   BG_COLOR_DEFAULT : colour shown where no layer is opaque
//   COORD_W          : VGA coordinate width
//   fsm_t            : mapper control states (INIT clears palettes, RUN)
// ----------------------------------------------------------------------------
package video_pkg;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BG_COLOR_DEFAULT = 24'h800080;

    typedef enum logic {
        INIT,
        RUN
    } fsm_t;

endpackage

// File: rtl/palette_ram.sv
// ----------------------------------------------------------------------------
// palette_ram
// One layer's colour palette: PAL_DEPTH entries of RGB888.
// Single write port plus one synchronous read-first read port, so a read of
// an entry being written on the same edge returns the old contents.
// Contents are not reset; the parent clears them at start-up.
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write entry
//   wdata : write colour
//   raddr : read entry, sampled on the rising edge
//   rdata : registered read colour
// ----------------------------------------------------------------------------
module palette_ram
    import video_pkg::*;
#(
    parameter int IDX_W     = 8,
    parameter int PAL_DEPTH = 256
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  rgb_t             wdata,
    input  logic [IDX_W-1:0] raddr,
    output rgb_t             rdata
);

    rgb_t mem [PAL_DEPTH];

    // Read and write share the edge; the read picks up the pre-write value.
    // Indices beyond the palette depth read as black and are never written.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < PAL_DEPTH)) begin
            mem[waddr] <= wdata;
        end
        if (int'(raddr) < PAL_DEPTH) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/layered_palette_mapper.sv
// ----------------------------------------------------------------------------
// layered_palette_mapper
// Composites NUM_LAYERS palette-indexed layers into one RGB888 VGA pixel.
// Each layer has its own writable palette; layer 0 has the highest priority
// and a per-layer transparent index lets lower layers show through. After
// reset every palette is filled with BG_COLOR before writes are accepted.
// Two-stage pipeline: 2 cycles latency, one pixel per cycle.
// A sticky collision flag reports any overlap of opaque layers in a frame.
//   Clk, Reset_n            : clock (rising edge), async active-low reset
//   pix_valid, blank        : pixel qualifiers
//   frame_start             : first pixel of a frame, clears collision
//   DrawX, DrawY            : pixel coordinates
//   layer_hit, layer_idx    : per-layer bounding-box hit and palette index
//   pal_we .. pal_wdata     : palette write request
//   pal_ready               : palette writes are being accepted
//   out_valid, out_DrawX/Y  : pipeline-aligned pixel qualifiers
//   VGA_R/G/B               : output colour
//   win_layer               : winning layer, NUM_LAYERS for background
//   collision               : sticky per-frame overlap flag
// ----------------------------------------------------------------------------
module layered_palette_mapper
    import video_pkg::*;
#(
    parameter int          NUM_LAYERS      = 3,
    parameter int          IDX_W           = 8,
    parameter int          PAL_DEPTH       = 256,
    parameter int          TRANSPARENT_IDX = 0,
    parameter logic [23:0] BG_COLOR        = BG_COLOR_DEFAULT,
    // pal_layer must be at least one bit wide even for a single layer
    localparam int         LAYER_W         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int         WIN_W           = $clog2(NUM_LAYERS) + 1
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        pix_valid,
    input  logic                        blank,
    input  logic                        frame_start,
    input  logic [COORD_W-1:0]          DrawX,
    input  logic [COORD_W-1:0]          DrawY,
    input  logic [NUM_LAYERS-1:0]       layer_hit,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic                        pal_we,
    input  logic [LAYER_W-1:0]          pal_layer,
    input  logic [IDX_W-1:0]            pal_addr,
    input  logic [23:0]                 pal_wdata,
    output logic                        pal_ready,
    output logic                        out_valid,
    output logic [COORD_W-1:0]          out_DrawX,
    output logic [COORD_W-1:0]          out_DrawY,
    output logic [7:0]                  VGA_R,
    output logic [7:0]                  VGA_G,
    output logic [7:0]                  VGA_B,
    output logic [WIN_W-1:0]            win_layer,
    output logic                        collision
);

    localparam logic [WIN_W-1:0] WIN_BG   = WIN_W'(NUM_LAYERS);
    localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(PAL_DEPTH - 1);
    localparam logic [IDX_W-1:0] TRANSP   = IDX_W'(TRANSPARENT_IDX);

    fsm_t             state;
    fsm_t             state_next;
    logic             in_init;
    logic [IDX_W-1:0] clr_cnt;

    logic             wr_accept;
    logic             ram_we    [NUM_LAYERS];
    logic [IDX_W-1:0] ram_waddr;
    rgb_t             ram_wdata;
    rgb_t             ram_rdata [NUM_LAYERS];

    logic [NUM_LAYERS-1:0] opaque_in;

    logic                  s1_valid;
    logic                  s1_blank;
    logic                  s1_frame_start;
    logic [COORD_W-1:0]    s1_x;
    logic [COORD_W-1:0]    s1_y;
    logic [NUM_LAYERS-1:0] s1_opaque;

    int               opaque_count;
    logic             s1_multi;
    logic [WIN_W-1:0] win_sel;
    rgb_t             win_color;

    // Control state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // INIT walks every palette entry once, then RUN holds until reset.
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (clr_cnt == CLR_LAST) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // Control outputs decoded from the state.
    always_comb begin
        in_init   = (state == INIT);
        pal_ready = (state == RUN);
    end

    // Clear address walked during INIT.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clr_cnt <= '0;
        end else if (in_init) begin
            clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + 1'b1;
        end
    end

    // During INIT all palettes share the clear write; afterwards only the
    // addressed palette sees a host write, and out-of-range targets match none.
    assign wr_accept = pal_we && pal_ready && (int'(pal_addr) < PAL_DEPTH);
    assign ram_waddr = in_init ? clr_cnt  : pal_addr;
    assign ram_wdata = in_init ? rgb_t'(BG_COLOR) : rgb_t'(pal_wdata);

    // One palette per layer, read with the incoming pixel index so the data
    // lines up with the S1 register contents.
    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        assign ram_we[g]    = in_init || (wr_accept && (pal_layer == LAYER_W'(g)));
        assign opaque_in[g] = layer_hit[g] && (layer_idx[g*IDX_W +: IDX_W] != TRANSP);

        palette_ram #(
            .IDX_W     (IDX_W),
            .PAL_DEPTH (PAL_DEPTH)
        ) u_pal (
            .clk   (Clk),
            .we    (ram_we[g]),
            .waddr (ram_waddr),
            .wdata (ram_wdata),
            .raddr (layer_idx[g*IDX_W +: IDX_W]),
            .rdata (ram_rdata[g])
        );
    end

    // S1: input register, alongside the palette reads.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid       <= 1'b0;
            s1_blank       <= 1'b0;
            s1_frame_start <= 1'b0;
            s1_x           <= '0;
            s1_y           <= '0;
            s1_opaque      <= '0;
        end else begin
            s1_valid       <= pix_valid;
            s1_blank       <= blank;
            s1_frame_start <= frame_start;
            s1_x           <= DrawX;
            s1_y           <= DrawY;
            s1_opaque      <= opaque_in;
        end
    end

    // Priority select: scanning from the background upward lets the
    // lowest-numbered opaque layer overwrite the choice last.
    always_comb begin
        win_sel      = WIN_BG;
        win_color    = rgb_t'(BG_COLOR);
        opaque_count = 0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_opaque[i]) begin
                win_sel   = WIN_W'(i);
                win_color = ram_rdata[i];
            end
        end
        for (int i = 0; i < NUM_LAYERS; i++) begin
            opaque_count = opaque_count + int'(s1_opaque[i]);
        end
        s1_multi = (opaque_count >= 2);
    end

    // S2: output register. Invalid and blanked pixels are forced to black.
    // A colliding pixel wins over frame_start because it opens the new frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            out_DrawX <= '0;
            out_DrawY <= '0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            win_layer <= WIN_BG;
            collision <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            out_DrawX <= s1_x;
            out_DrawY <= s1_y;
            if (!s1_valid || s1_blank) begin
                VGA_R     <= '0;
                VGA_G     <= '0;
                VGA_B     <= '0;
                win_layer <= WIN_BG;
            end else begin
                VGA_R     <= win_color.r;
                VGA_G     <= win_color.g;
                VGA_B     <= win_color.b;
                win_layer <= win_sel;
            end
            if (s1_valid && !s1_blank && s1_multi) begin
                collision <= 1'b1;
            end else if (s1_frame_start) begin
                collision <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_layered_palette_mapper.sv
// ----------------------------------------------------------------------------
// tb_layered_palette_mapper
// Directed self-checking bench for layered_palette_mapper with default
// parameters (3 layers, 8-bit indices, 256-entry palettes, BG 800080).
// ----------------------------------------------------------------------------
module tb_layered_palette_mapper;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid, blank, frame_start;
    logic [9:0]  DrawX, DrawY;
    logic [2:0]  layer_hit;
    logic [23:0] layer_idx;
    logic        pal_we;
    logic [1:0]  pal_layer;
    logic [7:0]  pal_addr;
    logic [23:0] pal_wdata;
    logic        pal_ready, out_valid, collision;
    logic [9:0]  out_DrawX, out_DrawY;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic [2:0]  win_layer;

    int checks = 0;
    int errors = 0;

    layered_palette_mapper dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .blank(blank),
        .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
        .layer_hit(layer_hit), .layer_idx(layer_idx), .pal_we(pal_we),
        .pal_layer(pal_layer), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .pal_ready(pal_ready), .out_valid(out_valid), .out_DrawX(out_DrawX),
        .out_DrawY(out_DrawY), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .win_layer(win_layer), .collision(collision)
    );

    always #5 Clk = ~Clk;

    // Drives one pixel's inputs; callers place it after a falling edge.
    task automatic set_pixel(input logic v, input logic b, input logic fs,
                             input logic [9:0] x, input logic [9:0] y,
                             input logic [2:0] hit, input logic [7:0] i0,
                             input logic [7:0] i1, input logic [7:0] i2);
        pix_valid   = v;
        blank       = b;
        frame_start = fs;
        DrawX       = x;
        DrawY       = y;
        layer_hit   = hit;
        layer_idx   = {i2, i1, i0};
    endtask

    task automatic idle_pixel();
        set_pixel(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 3'b000, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic write_pal(input logic [1:0] layer, input logic [7:0] addr,
                             input logic [23:0] data);
        @(negedge Clk);
        pal_we    = 1'b1;
        pal_layer = layer;
        pal_addr  = addr;
        pal_wdata = data;
        @(negedge Clk);
        pal_we    = 1'b0;
    endtask

    // Releases reset and counts falling edges until pal_ready; pokes a write
    // during INIT that must be ignored.
    task automatic release_and_count(output int cycles);
        Reset_n = 1'b1;
        cycles  = 0;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge Clk);
            cycles = n;
            if (n == 10) begin
                pal_we = 1'b1; pal_layer = 2'd1; pal_addr = 8'd5; pal_wdata = 24'h111111;
            end
            if (n == 11) pal_we = 1'b0;
            if (pal_ready) break;
        end
        pal_we = 1'b0;
    endtask

    task automatic test_reset();
        int cycles;
        Reset_n = 1'b0;
        pal_we = 1'b0; pal_layer = '0; pal_addr = '0; pal_wdata = '0;
        idle_pixel();
        repeat (3) @(negedge Clk);
        checks++;
        if ({pal_ready, out_valid, collision} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got ready/valid/coll=%b expected 000",
                     {pal_ready, out_valid, collision});
        end
        checks++;
        if ({VGA_R, VGA_G, VGA_B, out_DrawX, out_DrawY, win_layer} !== {24'h0, 10'd0, 10'd0, 3'd3}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rgb=%h x=%0d y=%0d win=%0d expected 000000/0/0/3",
                     {VGA_R, VGA_G, VGA_B}, out_DrawX, out_DrawY, win_layer);
        end
        release_and_count(cycles);
        checks++;
        if (cycles != 256 || !pal_ready) begin
            errors++;
            $display("[TB] FAIL init_length: got %0d cycles (ready=%b) expected 256", cycles, pal_ready);
        end
    endtask

    task automatic test_init_ignore();
        @(negedge Clk); set_pixel(1, 0, 0, 10'd1, 10'd2, 3'b010, 8'd0, 8'd5, 8'd0);
        @(negedge Clk); idle_pixel();
        @(negedge Clk);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, win_layer} !== {24'h800080, 3'd1}) begin
            errors++;
            $display("[TB] FAIL init_write_ignored: got rgb=%h win=%0d expected 800080/1",
                     {VGA_R, VGA_G, VGA_B}, win_layer);
        end
    endtask

    task automatic test_basic();
        write_pal(2'd1, 8'd5, 24'h123456);
        write_pal(2'd3, 8'd5, 24'hFFFFFF);
        @(negedge Clk); set_pixel(1, 0, 0, 10'd100, 10'd50, 3'b010, 8'd0, 8'd5, 8'd0);
        @(negedge Clk); idle_pixel();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_latency: got out_valid=%b after 1 cycle expected 0", out_valid);
        end
        @(negedge Clk);
        checks++;
        if ({out_valid, VGA_R, VGA_G, VGA_B, win_layer} !== {1'b1, 24'h123456, 3'd1}) begin
            errors++;
            $display("[TB] FAIL basic_pixel: got v=%b rgb=%h win=%0d expected 1/123456/1",
                     out_valid, {VGA_R, VGA_G, VGA_B}, win_layer);
        end
        checks++;
        if ({out_DrawX, out_DrawY, collision} !== {10'd100, 10'd50, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_coords: got x=%0d y=%0d coll=%b expected 100/50/0",
                     out_DrawX, out_DrawY, collision);
        end
    endtask

    task automatic test_priority();
        write_pal(2'd0, 8'd7, 24'hAABBCC);
        @(negedge Clk); set_pixel(1, 0, 0, 10'd10, 10'd11, 3'b011, 8'd7, 8'd5, 8'd0);
        @(negedge Clk); set_pixel(1, 0, 0, 10'd12, 10'd11, 3'b010, 8'd0, 8'd5, 8'd0);
        @(negedge Clk); idle_pixel();
        checks++;
        if ({VGA_R, VGA_G, VGA_B, win_layer, collision} !== {24'hAABBCC, 3'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL priority_pixel: got rgb=%h win=%0d coll=%b expected AABBCC/0/1",
                     {VGA_R, VGA_G, VGA_B}, win_layer, collision);
        end
        @(negedge Clk);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, win_layer, collision, out_DrawX} !== {24'h123456, 3'd1, 1'b1, 10'd12}) begin
            errors++;
            $display("[TB] FAIL collision_sticky: got rgb=%h win=%0d coll=%b x=%0d expected 123456/1/1/12",
                     {VGA_R, VGA_G, VGA_B}, win_layer, collision, out_DrawX);
        end
    endtask

    task automatic test_transparency_blank();
        @(negedge Clk); set_pixel(1, 0, 0, 10'd20, 10'd21, 3'b111, 8'd0, 8'd0, 8'd0);
        @(negedge Clk); set_pixel(1, 1, 0, 10'd20, 10'd21, 3'b111, 8'd0, 8'd0, 8'd0);
        @(negedge Clk); idle_pixel();
        checks++;
        if ({VGA_R, VGA_G, VGA_B, win_layer, collision} !== {24'h800080, 3'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL transparent_bg: got rgb=%h win=%0d coll=%b expected 800080/3/1",
                     {VGA_R, VGA_G, VGA_B}, win_layer, collision);
        end
        @(negedge Clk);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, win_layer} !== {24'h000000, 3'd3}) begin
            errors++;
            $display("[TB] FAIL blank_black: got rgb=%h win=%0d expected 000000/3",
                     {VGA_R, VGA_G, VGA_B}, win_layer);
        end
    endtask

    task automatic test_frame_start();
        @(negedge Clk); set_pixel(0, 0, 1, 10'd0, 10'd0, 3'b011, 8'd7, 8'd5, 8'd0);
        @(negedge Clk); idle_pixel();
        @(negedge Clk);
        checks++;
        if ({collision, out_valid, VGA_R, VGA_G, VGA_B} !== {1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("[TB] FAIL frame_start_clear: got coll=%b v=%b rgb=%h expected 0/0/000000",
                     collision, out_valid, {VGA_R, VGA_G, VGA_B});
        end
        @(negedge Clk); set_pixel(1, 0, 1, 10'd0, 10'd0, 3'b011, 8'd7, 8'd5, 8'd0);
        @(negedge Clk); idle_pixel();
        @(negedge Clk);
        checks++;
        if ({collision, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'hAABBCC}) begin
            errors++;
            $display("[TB] FAIL frame_start_set_wins: got coll=%b rgb=%h expected 1/AABBCC",
                     collision, {VGA_R, VGA_G, VGA_B});
        end
    endtask

    task automatic test_back_to_back_rw();
        @(negedge Clk);
        pal_we = 1'b1; pal_layer = 2'd1; pal_addr = 8'd5; pal_wdata = 24'h654321;
        set_pixel(1, 0, 0, 10'd30, 10'd31, 3'b010, 8'd0, 8'd5, 8'd0);
        @(negedge Clk);
        pal_we = 1'b0;
        set_pixel(1, 0, 0, 10'd31, 10'd31, 3'b010, 8'd0, 8'd5, 8'd0);
        @(negedge Clk); idle_pixel();
        checks++;
        if ({VGA_R, VGA_G, VGA_B, out_DrawX} !== {24'h123456, 10'd30}) begin
            errors++;
            $display("[TB] FAIL read_first_old: got rgb=%h x=%0d expected 123456/30",
                     {VGA_R, VGA_G, VGA_B}, out_DrawX);
        end
        @(negedge Clk);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, out_DrawX} !== {24'h654321, 10'd31}) begin
            errors++;
            $display("[TB] FAIL read_after_write_new: got rgb=%h x=%0d expected 654321/31",
                     {VGA_R, VGA_G, VGA_B}, out_DrawX);
        end
    endtask

    task automatic test_reset_mid_init();
        int cycles;
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({pal_ready, collision, win_layer} !== {1'b0, 1'b0, 3'd3}) begin
            errors++;
            $display("[TB] FAIL async_reset: got ready=%b coll=%b win=%0d expected 0/0/3",
                     pal_ready, collision, win_layer);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (100) @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        release_and_count(cycles);
        checks++;
        if (cycles != 256 || !pal_ready) begin
            errors++;
            $display("[TB] FAIL restart_init_length: got %0d cycles (ready=%b) expected 256", cycles, pal_ready);
        end
        @(negedge Clk); set_pixel(1, 0, 0, 10'd5, 10'd6, 3'b010, 8'd0, 8'd5, 8'd0);
        @(negedge Clk); idle_pixel();
        @(negedge Clk);
        checks++;
        if ({VGA_R, VGA_G, VGA_B, win_layer} !== {24'h800080, 3'd1}) begin
            errors++;
            $display("[TB] FAIL palette_recleared: got rgb=%h win=%0d expected 800080/1",
                     {VGA_R, VGA_G, VGA_B}, win_layer);
        end
    endtask

    initial begin
        $display("[TB] layered_palette_mapper directed test");
        test_reset();
        test_init_ignore();
        test_basic();
        test_priority();
        test_transparency_blank();
        test_frame_start();
        test_back_to_back_rw();
        test_reset_mid_init();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/layered_palette_mapper.md
Name: layered_palette_mapper

Overview:
Parametrised, pipelined successor to the single-cycle color mapper. Composites NUM_LAYERS sprite/background layers, each supplying a palette index per pixel, through per-layer writable palette RAMs. A fixed priority picks the winning colour, with one transparency index per layer. Sits between the sprite/background ROM fetch logic and the VGA output pins, and adds a sticky per-frame collision flag for game logic.

Parameters:
NUM_LAYERS, 3, number of layers; layer 0 has the highest priority, layer NUM_LAYERS-1 is the background.
IDX_W, 8, palette index width per layer.
PAL_DEPTH, 256, entries per layer palette; must be at most 2**IDX_W.
TRANSPARENT_IDX, 0, palette index treated as transparent on every layer.
BG_COLOR, 24'h800080, colour output when no layer is opaque.

Ports:
Clk  in  1  system clock; all state is on the rising edge.
Reset_n  in  1  asynchronous, active-low reset.
pix_valid  in  1  pixel inputs valid this cycle.
blank  in  1  VGA blanking for this pixel.
frame_start  in  1  one-cycle pulse at the first pixel of a frame.
DrawX  in  10  pixel X coordinate.
DrawY  in  10  pixel Y coordinate.
layer_hit  in  NUM_LAYERS  bit i: the pixel lies inside layer i's bounding box.
layer_idx  in  NUM_LAYERS*IDX_W  layer i index at bits [i*IDX_W +: IDX_W].
pal_we  in  1  palette write request.
pal_layer  in  $clog2(NUM_LAYERS)  target palette of the write.
pal_addr  in  IDX_W  target entry of the write.
pal_wdata  in  24  RGB888 write data.
pal_ready  out  1  high when palette writes are accepted.
out_valid  out  1  VGA_R/G/B correspond to a pixel accepted 2 cycles earlier.
out_DrawX  out  10  DrawX delayed to align with the colour.
out_DrawY  out  10  DrawY delayed to align with the colour.
VGA_R  out  8  red.
VGA_G  out  8  green.
VGA_B  out  8  blue.
win_layer  out  $clog2(NUM_LAYERS)+1  winning layer; value NUM_LAYERS means BG_COLOR.
collision  out  1  sticky: two or more layers were opaque on the same pixel this frame.

Behaviour:
- Reset (asynchronous): state=INIT, clear counter=0, pal_ready=0, out_valid=0, VGA_R/G/B=0, out_DrawX/Y=0, win_layer=NUM_LAYERS, collision=0.
- FSM INIT:
  - Writes BG_COLOR to entry cnt of every palette each cycle; cnt counts 0..PAL_DEPTH-1.
  - After the write to PAL_DEPTH-1, moves to RUN and pal_ready=1 on the next cycle. INIT therefore lasts exactly PAL_DEPTH cycles.
  - pal_we is ignored in INIT.
  - Pixels are still pipelined during INIT, and read BG_COLOR entries.
- FSM RUN: stays in RUN until reset. A reset mid-INIT restarts the clear from cnt=0.
- Palette write: accepted when pal_we && pal_ready. Takes effect on the clock edge. Writes with pal_addr >= PAL_DEPTH or pal_layer >= NUM_LAYERS are dropped.
- Palette RAMs have a synchronous read-first port. A read and a write to the same entry in the same cycle returns the old data. A read one cycle later returns the new data.
- Pipeline S1 (input register): captures pix_valid, blank, DrawX, DrawY and the per-layer opaque bits. Layer i is opaque when layer_hit[i] && layer_idx[i] != TRANSPARENT_IDX. S1 also issues the palette read addresses.
- Pipeline S2 (output register):
  - Winner is the lowest-numbered opaque layer; its RAM data drives VGA_R/G/B.
  - With no opaque layer, output BG_COLOR and win_layer=NUM_LAYERS.
  - If blank, output 0/0/0 and win_layer=NUM_LAYERS.
  - out_valid is the delayed pix_valid. Latency is 2 cycles, throughput is 1 pixel per cycle, and there are no bubbles.
- pix_valid=0: the pipeline shifts anyway. The output colour is don't-care but is driven to 0. collision is unaffected.
- Collision:
  - Set when a pixel at S1 has pix_valid && !blank and the popcount of its opaque bits is >= 2.
  - Cleared by frame_start.
  - If frame_start and a collision pixel arrive in the same cycle, collision=1 (set wins, since that pixel belongs to the new frame).
  - collision updates one cycle after the pixel is registered, aligned with out_valid.
- With NUM_LAYERS=1, collision stays 0.

Decomposition:
- Package video_pkg: rgb_t (packed struct r/g/b, 8 bits each), BG_COLOR default, VGA coordinate width constant (10), and the fsm_t enum {INIT, RUN}.
- Sub-module palette_ram (IDX_W, PAL_DEPTH; 1 write port, 1 read-first synchronous read port, no reset on contents). Instantiate it NUM_LAYERS times via generate.
- Priority select and popcount stay inline.

Test Plan:
- Reset, then idle: pal_ready rises exactly 256 cycles after Reset_n deasserts. A pal_we during INIT to layer 1 entry 5 has no effect; a later pixel reading it shows 80/00/80.
- After INIT:
  - Write layer1[5]=0x123456.
  - Present a pixel with layer_hit=3'b010, idx1=5, DrawX=100, DrawY=50.
  - 2 cycles later: out_valid=1, RGB=12/34/56, win_layer=1, out_DrawX=100, out_DrawY=50, collision=0.
- Priority:
  - Write layer0[7]=0xAABBCC.
  - Present a pixel with layer_hit=3'b011, idx0=7, idx1=5.
  - Expected: RGB=AA/BB/CC, win_layer=0, collision=1 and held over subsequent non-colliding pixels.
- Transparency and blank:
  - layer_hit=3'b111 with all idx=0 -> 80/00/80, win_layer=3, collision unchanged.
  - Same pixel with blank=1 -> 00/00/00.
- frame_start alone -> collision=0 next cycle. frame_start together with a 2-layer overlap pixel -> collision=1.
- Same-cycle write and read of layer1[5] (old 0x123456, new 0x654321): that pixel outputs 12/34/56, the next pixel 65/43/21. Reset_n pulsed mid-INIT: pal_ready stays low for a full 256 cycles after release.
